// File: rtl/vga_frame_monitor_if.sv
// Bundle of the sampled VGA output pins and the CPU register bus.
// The generator/CPU side uses master; the frame monitor uses slave.
interface vga_frame_monitor_if;
    logic        vga_clk;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_blank_n;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;
    logic        chipselect;
    logic        write;
    logic [2:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        frame_done;
    logic        error;

    modport master (
        output vga_clk, vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b,
        output chipselect, write, address, writedata,
        input  readdata, frame_done, error
    );

    modport slave (
        input  vga_clk, vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b,
        input  chipselect, write, address, writedata,
        output readdata, frame_done, error
    );
endinterface

// File: rtl/vga_frame_monitor.sv
// Samples the off-chip VGA pins, measures line/frame timing and a per-frame
// CRC-16-CCITT of active pixels, and exposes the results on a register slave.
module vga_frame_monitor #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_TOTAL  = 525
) (
    input logic             clk,
    input logic             reset,
    vga_frame_monitor_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT_VS = 2'd1, FRAME = 2'd2} state_t;

    localparam logic [15:0] H_ACT_EXP = 16'(H_ACTIVE);
    localparam logic [15:0] V_ACT_EXP = 16'(V_ACTIVE);
    localparam logic [15:0] V_TOT_EXP = 16'(V_TOTAL);

    logic        clk_q, clk_qq, hs_q, hs_qd, vs_q, vs_qd, blank_q;
    logic [4:0]  r_q, g_q, b_q;
    logic        ps, hs_fall, vs_fall, act_ps, hs_ps, line_active, vs_line;
    logic [15:0] pix_word;
    logic        ctrl_wr, rd_en, clear_errors;

    state_t      state;
    logic        enable, line_err, frame_err, frame_done_r;
    logic [15:0] clk_cnt, act_cnt, hs_cnt, line_cnt, act_lines, vs_lines, crc;
    logic [15:0] h_total, h_act, hs_w, v_total_m, v_act, vs_w, crc_lat, frame_count;
    logic [31:0] rdata;
    logic        unused;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [15:0] crc_next(input logic [15:0] c_in, input logic [15:0] d_in);
        logic [15:0] c;
        logic [15:0] d;
        logic        fb;
        c = c_in;
        d = d_in;
        for (int unsigned i = 0; i < 16; i++) begin
            fb = c[15] ^ d[15];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
            d  = {d[14:0], 1'b0};
        end
        return c;
    endfunction

    assign ps          = clk_q & ~clk_qq;
    assign hs_fall     = hs_qd & ~hs_q;
    assign vs_fall     = vs_qd & ~vs_q;
    assign act_ps      = ps & blank_q;
    assign hs_ps       = ps & ~hs_q;
    assign line_active = hs_fall & (act_cnt != '0);
    assign vs_line     = hs_fall & ~vs_q;
    assign pix_word    = {1'b0, r_q, g_q, b_q};

    assign ctrl_wr      = bus.chipselect & bus.write & (bus.address == 3'd0);
    assign clear_errors = ctrl_wr & bus.writedata[1];
    assign rd_en        = bus.chipselect & ~bus.write;

    assign bus.readdata   = rdata;
    assign bus.frame_done = frame_done_r;
    assign bus.error      = line_err | frame_err;
    assign unused = ^{bus.writedata[31:2], bus.vga_r[2:0], bus.vga_g[2:0], bus.vga_b[2:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_q   <= 1'b0;
            clk_qq  <= 1'b0;
            hs_q    <= 1'b0;
            hs_qd   <= 1'b0;
            vs_q    <= 1'b0;
            vs_qd   <= 1'b0;
            blank_q <= 1'b0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
        end else begin
            clk_q   <= bus.vga_clk;
            clk_qq  <= clk_q;
            hs_q    <= bus.vga_hs;
            hs_qd   <= hs_q;
            vs_q    <= bus.vga_vs;
            vs_qd   <= vs_q;
            blank_q <= bus.vga_blank_n;
            r_q     <= bus.vga_r[7:3];
            g_q     <= bus.vga_g[7:3];
            b_q     <= bus.vga_b[7:3];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            enable       <= 1'b0;
            line_err     <= 1'b0;
            frame_err    <= 1'b0;
            frame_done_r <= 1'b0;
            frame_count  <= '0;
            clk_cnt      <= '0;
            act_cnt      <= '0;
            hs_cnt       <= '0;
            line_cnt     <= '0;
            act_lines    <= '0;
            vs_lines     <= '0;
            crc          <= '0;
            h_total      <= '0;
            h_act        <= '0;
            hs_w         <= '0;
            v_total_m    <= '0;
            v_act        <= '0;
            vs_w         <= '0;
            crc_lat      <= '0;
        end else begin
            frame_done_r <= 1'b0;
            if (frame_done_r) frame_count <= frame_count + 16'd1;
            if (ctrl_wr) enable <= bus.writedata[0];
            // Clears come first so that a same-cycle error set below wins.
            if (clear_errors) begin
                line_err  <= 1'b0;
                frame_err <= 1'b0;
            end
            if (!enable) begin
                state     <= IDLE;
                clk_cnt   <= '0;
                act_cnt   <= '0;
                hs_cnt    <= '0;
                line_cnt  <= '0;
                act_lines <= '0;
                vs_lines  <= '0;
                crc       <= 16'hFFFF;
            end else begin
                case (state)
                    IDLE:    state <= WAIT_VS;
                    WAIT_VS: if (vs_fall) begin
                        state <= FRAME;
                        crc   <= 16'hFFFF;
                    end
                    FRAME: begin
                        // The edge cycle itself belongs to the new line/frame.
                        clk_cnt <= hs_fall ? 16'd1 : sat_inc(clk_cnt);
                        if (hs_fall) begin
                            h_total <= clk_cnt;
                            h_act   <= act_cnt;
                            hs_w    <= hs_cnt;
                            act_cnt <= {15'd0, act_ps};
                            hs_cnt  <= {15'd0, hs_ps};
                            if (act_cnt != '0 && act_cnt != H_ACT_EXP) line_err <= 1'b1;
                        end else begin
                            if (act_ps) act_cnt <= sat_inc(act_cnt);
                            if (hs_ps)  hs_cnt  <= sat_inc(hs_cnt);
                        end
                        if (vs_fall) begin
                            v_total_m    <= line_cnt;
                            v_act        <= act_lines;
                            vs_w         <= vs_lines;
                            crc_lat      <= crc;
                            frame_done_r <= 1'b1;
                            if (act_lines != V_ACT_EXP || line_cnt != V_TOT_EXP) frame_err <= 1'b1;
                            line_cnt  <= {15'd0, hs_fall};
                            act_lines <= {15'd0, line_active};
                            vs_lines  <= {15'd0, vs_line};
                            crc       <= act_ps ? crc_next(16'hFFFF, pix_word) : 16'hFFFF;
                        end else begin
                            if (hs_fall)     line_cnt  <= sat_inc(line_cnt);
                            if (line_active) act_lines <= sat_inc(act_lines);
                            if (vs_line)     vs_lines  <= sat_inc(vs_lines);
                            if (act_ps)      crc       <= crc_next(crc, pix_word);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (rd_en) begin
            case (bus.address)
                3'd0:    rdata <= {31'd0, enable};
                3'd1:    rdata <= {frame_count, 12'd0, state, frame_err, line_err};
                3'd2:    rdata <= {h_total, h_act};
                3'd3:    rdata <= {v_total_m, v_act};
                3'd4:    rdata <= {hs_w, vs_w};
                3'd5:    rdata <= {16'd0, crc_lat};
                default: rdata <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_vga_frame_monitor.sv
// Scoreboard bench for vga_frame_monitor using a scaled-down raster:
// 12 pixels x 10 lines, 8 active pixels, 6 active lines, 2-pixel HS, 2-line VS.
module tb_vga_frame_monitor;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vga_frame_monitor_if bus ();

    vga_frame_monitor #(.H_ACTIVE(8), .V_ACTIVE(6), .V_TOTAL(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;

    exp_t        sbq[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          fd_cnt = 0;
    int          fd_base = 0;
    logic        rd_fire = 1'b0;
    logic [15:0] gen_crc, crc_last, crc_prev;

    // Byte-at-a-time CRC-16-CCITT reference (MSB first, no reflection).
    function automatic logic [15:0] crc_model(input logic [15:0] c_in, input logic [15:0] w);
        logic [15:0] c;
        logic [7:0]  byt;
        c = c_in;
        for (int k = 0; k < 2; k++) begin
            byt = (k == 0) ? w[15:8] : w[7:0];
            c = c ^ {byt, 8'h00};
            for (int j = 0; j < 8; j++)
                c = c[15] ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
        end
        return c;
    endfunction

    always @(posedge clk) rd_fire <= bus.chipselect && !bus.write;

    always @(negedge clk) begin
        exp_t e;
        if (bus.frame_done === 1'b1) fd_cnt++;
        if (rd_fire) begin
            vectors++;
            if (sbq.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_read: readdata %h, no expectation queued", bus.readdata);
            end else begin
                e = sbq.pop_front();
                if (bus.readdata !== e.exp) begin
                    miscompares++;
                    $display("FAIL %s: readdata %h, expected %h", e.name, bus.readdata, e.exp);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
        exp_t e;
        e.name = name;
        e.exp  = exp;
        @(negedge clk);
        bus.chipselect = 1'b1;
        bus.write      = 1'b0;
        bus.address    = a;
        sbq.push_back(e);
        @(negedge clk);
        bus.chipselect = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.address    = a;
        bus.writedata  = d;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
    endtask

    // One line: active pixels 0..n_act-1, HS low on pixels 9-10; two clk per pixel.
    task automatic gen_line(input bit act_line, input bit vs_low, input int n_act, input int spx_col);
        logic [7:0] r, g, b;
        bit         act;
        g = 8'h50;
        b = 8'h28;
        for (int p = 0; p < 12; p++) begin
            act = act_line && (p < n_act);
            r = (p == spx_col) ? 8'h08 : 8'hC8;
            if (act) gen_crc = crc_model(gen_crc, {1'b0, r[7:3], g[7:3], b[7:3]});
            @(negedge clk);
            bus.vga_clk     = 1'b0;
            bus.vga_hs      = !(p == 9 || p == 10);
            bus.vga_vs      = !vs_low;
            bus.vga_blank_n = act;
            bus.vga_r       = act ? r : 8'h00;
            bus.vga_g       = act ? g : 8'h00;
            bus.vga_b       = act ? b : 8'h00;
            @(negedge clk);
            bus.vga_clk = 1'b1;
        end
    endtask

    // Blank lines first (VS on lines 1-2), last six lines active.
    task automatic gen_frame(input int lines, input int short_line, input int spx_line);
        crc_prev = crc_last;
        gen_crc  = 16'hFFFF;
        for (int l = 0; l < lines; l++)
            gen_line(l >= lines - 6, l == 1 || l == 2, (l == short_line) ? 7 : 8,
                     (l == spx_line) ? 4 : -1);
        crc_last = gen_crc;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.vga_clk = 1'b0;  bus.vga_hs = 1'b1;  bus.vga_vs = 1'b1;  bus.vga_blank_n = 1'b0;
        bus.vga_r = 8'h00;   bus.vga_g = 8'h00;  bus.vga_b = 8'h00;
        bus.chipselect = 1'b0; bus.write = 1'b0; bus.address = 3'd0; bus.writedata = 32'h0;
        crc_last = 16'hFFFF;
        crc_prev = 16'hFFFF;
        gen_crc  = 16'hFFFF;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        chk("rst_error", {31'd0, bus.error}, 32'd0);
        chk("rst_frame_done", {31'd0, bus.frame_done}, 32'd0);
        for (int a = 0; a < 8; a++) rd(3'(a), 32'h0, $sformatf("rst_reg%0d", a));

        // Clean frames; CRC and timing of each closed frame.
        wr(3'd0, 32'h1);
        gen_frame(10, -1, -1);
        chk("fd_after_entry", fd_cnt, 0);
        gen_frame(10, -1, -1);
        rd(3'd5, {16'h0, crc_prev}, "crc_frame1");
        gen_frame(10, -1, 6);
        rd(3'd2, 32'h0018_0008, "h_timing");
        rd(3'd3, 32'h000A_0006, "v_timing");
        rd(3'd4, 32'h0002_0002, "sync_widths");
        rd(3'd1, 32'h0002_0008, "status_two_frames");
        rd(3'd5, {16'h0, crc_prev}, "crc_frame2");
        chk("fd_two_frames", fd_cnt, 2);
        chk("error_clean", {31'd0, bus.error}, 32'd0);
        gen_frame(10, -1, -1);
        rd(3'd5, {16'h0, crc_prev}, "crc_frame3_pixel_changed");

        // One 7-pixel line, then clear with enable held.
        gen_frame(10, 5, -1);
        rd(3'd1, 32'h0004_0009, "status_line_err");
        chk("error_line_err", {31'd0, bus.error}, 32'd1);
        wr(3'd0, 32'h3);
        rd(3'd1, 32'h0004_0008, "status_cleared");
        rd(3'd0, 32'h0000_0001, "ctrl_enable_kept");
        gen_frame(10, -1, -1);
        rd(3'd1, 32'h0005_0008, "status_clean_after_clear");
        chk("error_after_clear", {31'd0, bus.error}, 32'd0);

        // A 9-line frame shows up in the window closed by the following VS.
        gen_frame(9, -1, -1);
        gen_frame(10, -1, -1);
        rd(3'd1, 32'h0007_000A, "status_frame_err");
        rd(3'd3, 32'h0009_0006, "v_timing_short");
        chk("error_frame_err", {31'd0, bus.error}, 32'd1);

        // No sync for longer than the 16-bit line counter can hold.
        repeat (66000) @(negedge clk);
        rd(3'd2, 32'h0018_0008, "h_hold_no_sync");
        rd(3'd1, 32'h0007_000A, "status_hold_no_sync");
        chk("fd_hold_no_sync", fd_cnt, 7);
        gen_line(1'b1, 1'b0, 8, -1);
        rd(3'd2, 32'hFFFF_0008, "h_total_saturated");

        // Asynchronous reset while in FRAME.
        chk("error_before_reset", {31'd0, bus.error}, 32'd1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 chk("error_async_reset", {31'd0, bus.error}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int a = 0; a < 6; a++) rd(3'(a), 32'h0, $sformatf("reset_reg%0d", a));

        // Disable mid-frame, re-enable: first partial frame is discarded.
        wr(3'd0, 32'h1);
        gen_frame(10, -1, -1);
        wr(3'd0, 32'h0);
        rd(3'd1, 32'h0000_0000, "status_disabled");
        wr(3'd0, 32'h1);
        rd(3'd1, 32'h0000_0004, "status_wait_vs");
        fd_base = fd_cnt;
        gen_frame(10, -1, -1);
        chk("fd_partial_discarded", fd_cnt - fd_base, 0);
        gen_frame(10, -1, -1);
        chk("fd_after_reenable", fd_cnt - fd_base, 1);
        rd(3'd1, 32'h0001_0008, "status_after_reenable");
        rd(3'd3, 32'h000A_0006, "v_timing_after_reenable");

        repeat (4) @(negedge clk);
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d reads never answered", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
